// File: rtl/key_scan_debounce_pkg.sv
// Shared types and defaults for the key scanning front end.
package key_pkg;

  localparam int unsigned NUM_KEYS_DEF = 16;
  localparam int unsigned DEBOUNCE_DEF = 25000;

  function automatic int unsigned key_w(input int unsigned num_keys);
    return (num_keys < 2) ? 1 : $clog2(num_keys);
  endfunction

  localparam int unsigned KEY_W_DEF = key_w(NUM_KEYS_DEF);

  typedef struct packed {
    logic                 pressed;
    logic [KEY_W_DEF-1:0] code;
  } key_event_t;

endpackage

// File: rtl/key_scan_debounce_if.sv
// Key event handshake towards the Keyboard block: show-ahead head event plus ready.
interface key_scan_debounce_if #(
  parameter int unsigned KEY_W = key_pkg::KEY_W_DEF
) ();

  logic [KEY_W-1:0] key_code;
  logic             key_pressed;
  logic             key_valid;
  logic             key_ready;

  modport master (
    output key_code,
    output key_pressed,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_pressed,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/key_debounce.sv
// Per-key two-flop synchronizer and stable-count debouncer with an event strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic evt
);

  localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // evt is combinational so the pending flag is set on the same edge stable flips
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt      = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = sync2_q;
      evt      = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_scan_debounce.sv
// Debounces raw key lines, turns level changes into events and queues them in a small FIFO.
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = NUM_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                overflow,
  key_scan_debounce_if.master kbd
);

  localparam int unsigned     KEY_W   = key_w(NUM_KEYS);
  localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

  typedef struct packed {
    logic             pressed;
    logic [KEY_W-1:0] code;
  } event_t;

  logic [NUM_KEYS-1:0] stable, evt;
  logic [NUM_KEYS-1:0] pend_q, pend_d, type_q, type_d;
  logic                overflow_q, overflow_d;
  logic                sel_found;
  logic [KEY_W-1:0]    sel;
  logic [PTR_W:0]      wptr_q, rptr_q;
  logic                full, empty, push, pop;
  event_t              mem_q [FIFO_DEPTH];
  event_t              head;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_keys[i]),
      .stable(stable[i]),
      .evt   (evt[i])
    );
  end

  // Fixed priority: lowest pending index wins
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_q[i] && !sel_found) begin
        sel_found = 1'b1;
        sel       = KEY_W'(i);
      end
    end
  end

  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = sel_found && !full;
  assign pop   = !empty && kbd.key_ready;

  // A new event on a key whose previous event is still unqueued replaces it and is lost
  always_comb begin
    pend_d     = pend_q;
    type_d     = type_q;
    overflow_d = overflow_q;
    if (push) begin
      pend_d[sel] = 1'b0;
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (evt[i]) begin
        if (pend_d[i]) begin
          overflow_d = 1'b1;
        end
        pend_d[i] = 1'b1;
        type_d[i] = ~stable[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      type_q     <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      type_q     <= type_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wptr_q[PTR_W-1:0]] <= '{pressed: type_q[sel], code: sel};
        wptr_q                   <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

  assign head            = mem_q[rptr_q[PTR_W-1:0]];
  assign kbd.key_valid   = !empty;
  assign kbd.key_code    = head.code;
  assign kbd.key_pressed = head.pressed;
  assign key_state       = stable;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Bench for key_scan_debounce: history-based reference model feeding a scoreboard queue.
module tb_key_scan_debounce;
  import key_pkg::*;

  localparam int unsigned NK = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned FD = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [NK-1:0] raw_keys = '0;
  logic [NK-1:0] key_state;
  logic          overflow;

  key_scan_debounce_if #(.KEY_W(KEY_W_DEF)) kbd_if ();

  key_scan_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_keys (raw_keys),
    .key_state(key_state),
    .overflow (overflow),
    .kbd      (kbd_if)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw sample history per key, pending set, queue-based FIFO
  logic [D:0]    hist [NK];
  logic [NK-1:0] m_stable, m_pend, m_type;
  logic          m_ovf;
  key_event_t    m_fifo[$];
  key_event_t    exp_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < NK; k++) hist[k] = '0;
        m_stable = '0;
        m_pend   = '0;
        m_type   = '0;
        m_ovf    = 1'b0;
        m_fifo.delete();
        exp_q.delete();
      end else begin
        logic [NK-1:0] ev;
        bit            found;
        bit            do_push;
        int            sel;
        key_event_t    e;
        // A level is accepted once the synchronized samples disagree with it D times running
        for (int k = 0; k < NK; k++) begin
          ev[k]   = m_stable[k] ? (hist[k][D:1] == '0) : (&hist[k][D:1]);
          hist[k] = {hist[k][D-1:0], raw_keys[k]};
        end
        found = 0;
        sel   = 0;
        for (int k = 0; k < NK; k++) begin
          if (m_pend[k] && !found) begin
            found = 1;
            sel   = k;
          end
        end
        do_push = found && (m_fifo.size() < FD);
        if (m_fifo.size() > 0 && kbd_if.key_ready) void'(m_fifo.pop_front());
        if (do_push) begin
          e.pressed = m_type[sel];
          e.code    = KEY_W_DEF'(sel);
          m_fifo.push_back(e);
          exp_q.push_back(e);
          m_pend[sel] = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
          if (ev[k]) begin
            if (m_pend[k]) m_ovf = 1'b1;
            m_pend[k]   = 1'b1;
            m_type[k]   = ~m_stable[k];
            m_stable[k] = ~m_stable[k];
          end
        end
      end
    end
  end

  // Monitor: per-cycle status plus scoreboard pop on every handshake
  initial begin
    forever begin
      @(negedge clk);
      chk("key_state", key_state, m_stable);
      chk("overflow", overflow, m_ovf);
      chk("key_valid", kbd_if.key_valid, m_fifo.size() != 0);
      if (rst_n && kbd_if.key_valid && kbd_if.key_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected event code", kbd_if.key_code, 32'hffff_ffff);
        end else begin
          key_event_t e;
          e = exp_q.pop_front();
          chk("event code", kbd_if.key_code, e.code);
          chk("event pressed", kbd_if.key_pressed, e.pressed);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  initial begin
    kbd_if.key_ready = 1'b0;
    tick(2);
    chk("reset key_valid", kbd_if.key_valid, 0);
    chk("reset key_code", kbd_if.key_code, 0);
    chk("reset key_pressed", kbd_if.key_pressed, 0);
    chk("reset key_state", key_state, 0);
    chk("reset overflow", overflow, 0);
    rst_n = 1'b1;

    // Clean press
    kbd_if.key_ready = 1'b1;
    raw_keys[5] = 1'b1;
    tick(12);
    raw_keys = '0;
    tick(12);

    // Bounce shorter than the debounce window
    for (int b = 0; b < 2; b++) begin
      raw_keys[3] = 1'b1;
      tick(2);
      raw_keys[3] = 1'b0;
      tick(2);
    end
    raw_keys[3] = 1'b1;
    tick(12);
    raw_keys = '0;
    tick(12);

    // Simultaneous presses drain in index order
    raw_keys[9]  = 1'b1;
    raw_keys[2]  = 1'b1;
    raw_keys[14] = 1'b1;
    tick(12);
    raw_keys = '0;
    tick(12);

    // Backpressure: FIFO fills, extra events wait pending
    kbd_if.key_ready = 1'b0;
    raw_keys[5:0] = '1;
    tick(14);
    kbd_if.key_ready = 1'b1;
    tick(12);

    // Lost event: key 7 press overwritten by its release while FIFO is full
    kbd_if.key_ready = 1'b0;
    raw_keys[3:0] = '0;
    tick(10);
    raw_keys[7] = 1'b1;
    tick(8);
    raw_keys[7] = 1'b0;
    tick(8);
    chk("overflow after lost event", overflow, 1);
    kbd_if.key_ready = 1'b1;
    tick(16);
    raw_keys = '0;
    tick(12);

    // Reset with events queued and key 1 held
    kbd_if.key_ready = 1'b0;
    raw_keys[11:10] = 2'b11;
    tick(9);
    raw_keys[1] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid reset key_valid", kbd_if.key_valid, 0);
    chk("mid reset key_code", kbd_if.key_code, 0);
    chk("mid reset key_pressed", kbd_if.key_pressed, 0);
    chk("mid reset key_state", key_state, 0);
    chk("mid reset overflow", overflow, 0);
    tick(2);
    rst_n = 1'b1;
    kbd_if.key_ready = 1'b1;
    tick(12);
    raw_keys = '0;
    tick(12);

    // Random key activity and random backpressure
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, NK - 1);
        raw_keys[k] = ~raw_keys[k];
      end
      kbd_if.key_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    kbd_if.key_ready = 1'b1;
    tick(60);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
